// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: FSM state encoding and parameter legality checks for run_ctrl.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STEP = 2'd2,
      S_HALT = 2'd3
   } state_e;

   function automatic bit div_ok(input int div);
      return div >= 2;
   endfunction

   function automatic bit phase_ok(input int div, input int phase);
      return phase >= 0 && phase <= div - 2;
   endfunction

endpackage

// File: rtl/run_ctrl_ce_divider.sv
// ce_divider: board-cycle divider for run_ctrl; strobes look one cycle ahead so
// the enables that use them can be registered.
module ce_divider #(
   parameter int DIV       = 4,
   parameter int MEM_PHASE = 1
) (
   input  logic clock,
   input  logic reset,
   output logic zero_o,
   output logic mem_nxt_o,
   output logic last_nxt_o
);

   localparam int DW = $clog2(DIV);

   logic [DW-1:0] div_q, div_d;

   always_comb div_d = (div_q == DW'(DIV - 1)) ? '0 : div_q + DW'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) div_q <= '0;
      else        div_q <= div_d;
   end

   assign zero_o     = div_q == '0;
   assign mem_nxt_o  = div_d == DW'(MEM_PHASE);
   assign last_nxt_o = div_d == DW'(DIV - 1);

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: run/step/breakpoint clock-enable controller for the single-cycle CPU.
// Define RUN_CTRL_CYCLE_COUNT_EN to build the retired-cycle counter.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int DIV       = 4,
   parameter int MEM_PHASE = 1,
   parameter int ADDR_W    = 8,
   parameter int CNT_W     = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic              bp_valid,
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              cpu_ce,
   output logic              mem_ce,
   output logic              cpu_start,
   output logic              running,
   output logic              halted,
   output logic [CNT_W-1:0]  cycle_count
);

   if (!div_ok(DIV)) begin : g_bad_div
      $fatal(1, "run_ctrl: DIV must be >= 2");
   end
   if (!phase_ok(DIV, MEM_PHASE)) begin : g_bad_phase
      $fatal(1, "run_ctrl: MEM_PHASE must be in 0..DIV-2");
   end

   logic   zero, mem_nxt, last_nxt;
   state_e state_q, state_d;
   logic   grant_q, grant_d, step_pend_q, step_pend_d, bp_skip_q, bp_skip_d;
   logic   first_q, first_d, cpu_ce_d, mem_ce_d, start_d, stp, hit, leave_idle;

   ce_divider #(.DIV(DIV), .MEM_PHASE(MEM_PHASE)) u_div (
      .clock     (clock),
      .reset     (reset),
      .zero_o    (zero),
      .mem_nxt_o (mem_nxt),
      .last_nxt_o(last_nxt)
   );

   always_comb begin
      stp         = step_pend_q | step;
      hit         = bp_valid && i_addr == bp_addr && !bp_skip_q;
      state_d     = state_q;
      grant_d     = grant_q;
      step_pend_d = stp;
      bp_skip_d   = bp_skip_q;
      if (zero) begin
         step_pend_d = 1'b0;
         bp_skip_d   = 1'b0;
         case (state_q)
            S_IDLE: begin
               state_d = run ? S_RUN : stp ? S_STEP : S_IDLE;
               grant_d = run | stp;
            end
            S_RUN: begin
               state_d = (!run || hit) ? S_HALT : S_RUN;
               grant_d = run && !hit;
            end
            S_STEP: begin
               state_d = S_HALT;
               grant_d = 1'b0;
            end
            default: begin
               state_d   = run ? S_RUN : stp ? S_STEP : S_HALT;
               grant_d   = run | stp;
               bp_skip_d = run | stp;
            end
         endcase
      end
      leave_idle = zero && state_q == S_IDLE && grant_d;
      cpu_ce_d   = grant_d && last_nxt;
      mem_ce_d   = grant_d && mem_nxt;
      start_d    = (first_q | leave_idle) && cpu_ce_d;
      first_d    = (first_q | leave_idle) && !cpu_ce_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         grant_q     <= 1'b0;
         step_pend_q <= 1'b0;
         bp_skip_q   <= 1'b0;
         first_q     <= 1'b0;
         cpu_ce      <= 1'b0;
         mem_ce      <= 1'b0;
         cpu_start   <= 1'b0;
         running     <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         step_pend_q <= step_pend_d;
         bp_skip_q   <= bp_skip_d;
         first_q     <= first_d;
         cpu_ce      <= cpu_ce_d;
         mem_ce      <= mem_ce_d;
         cpu_start   <= start_d;
         running     <= state_d == S_RUN;
         halted      <= state_d == S_HALT;
      end
   end

`ifdef RUN_CTRL_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_q + CNT_W'(cpu_ce);
   end
   assign cycle_count = cnt_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed checks of run_ctrl with DIV=4, MEM_PHASE=1, CNT_W=4;
// cycle k counts board cycles from reset release (div == k % 4).
module tb_run_ctrl;

   logic       clock = 1'b0;
   logic       reset, run, step, bp_valid;
   logic [7:0] bp_addr, i_addr;
   logic       cpu_ce, mem_ce, cpu_start, running, halted;
   logic [3:0] cycle_count;
   int         vec = 0, errs = 0, cyc = 0;

   always #5 clock = ~clock;

   run_ctrl #(.DIV(4), .MEM_PHASE(1), .ADDR_W(8), .CNT_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .step       (step),
      .bp_valid   (bp_valid),
      .bp_addr    (bp_addr),
      .i_addr     (i_addr),
      .cpu_ce     (cpu_ce),
      .mem_ce     (mem_ce),
      .cpu_start  (cpu_start),
      .running    (running),
      .halted     (halted),
      .cycle_count(cycle_count)
   );

   function automatic int ecnt(input int n);
`ifdef RUN_CTRL_CYCLE_COUNT_EN
      return n % 16;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic adv(input int k);
      while (cyc < k) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   task automatic rel();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      rel();
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; step = 1'b0; bp_valid = 1'b0; bp_addr = '0; i_addr = '0;
      rel();
      chk("rst cpu_ce", cpu_ce, 0);
      chk("rst mem_ce", mem_ce, 0);
      chk("rst cpu_start", cpu_start, 0);
      chk("rst running", running, 0);
      chk("rst halted", halted, 0);
      chk("rst count", cycle_count, 0);
      // reset then run: cpu_ce at 3,7,11; mem_ce two cycles earlier
      run = 1'b1;
      for (int k = 1; k < 12; k++) begin
         adv(k);
         chk("run cpu_ce", cpu_ce, int'(k % 4 == 3));
         chk("run mem_ce", mem_ce, int'(k % 4 == 1));
         chk("run cpu_start", cpu_start, int'(k == 3));
         chk("run running", running, 1);
         chk("run count", cycle_count, ecnt(k / 4));
      end
      // run drop mid-window: current window completes, next is withheld
      adv(13); run = 1'b0;
      adv(15); chk("drop cpu_ce", cpu_ce, 1);
      adv(17);
      chk("drop halted", halted, 1);
      chk("drop running", running, 0);
      chk("drop count", cycle_count, ecnt(4));
      chk("drop mem_ce", mem_ce, 0);
      adv(18); run = 1'b1;
      adv(19); chk("drop idle cpu_ce", cpu_ce, 0);
      adv(21);
      chk("resume mem_ce", mem_ce, 1);
      chk("resume running", running, 1);
      chk("resume halted", halted, 0);
      // reset at div==2 of a granted window
      adv(22);
      reset = 1'b0;
      #1;
      chk("mrst cpu_ce", cpu_ce, 0);
      chk("mrst mem_ce", mem_ce, 0);
      chk("mrst running", running, 0);
      chk("mrst halted", halted, 0);
      chk("mrst count", cycle_count, 0);
      run = 1'b0;
      rel();
      // single step from IDLE, pulse at div==2
      adv(1);
      chk("idle running", running, 0);
      chk("idle halted", halted, 0);
      chk("idle mem_ce", mem_ce, 0);
      adv(2); step = 1'b1;
      adv(3); step = 1'b0;
      chk("idle cpu_ce", cpu_ce, 0);
      adv(5);
      chk("step mem_ce", mem_ce, 1);
      chk("step running", running, 0);
      chk("step halted", halted, 0);
      adv(7);
      chk("step cpu_ce", cpu_ce, 1);
      chk("step cpu_start", cpu_start, 1);
      adv(9);
      chk("step halted", halted, 1);
      chk("step count", cycle_count, ecnt(1));
      adv(11); chk("step once cpu_ce", cpu_ce, 0);
      adv(13); chk("step once mem_ce", mem_ce, 0);
      // breakpoint at 5, then resume past it
      do_reset();
      bp_valid = 1'b1; bp_addr = 8'h05; i_addr = 8'h03; run = 1'b1;
      adv(3); chk("bp exec3 cpu_ce", cpu_ce, 1); i_addr = 8'h04;
      adv(7); chk("bp exec4 cpu_ce", cpu_ce, 1); i_addr = 8'h05;
      adv(9);
      chk("bp halted", halted, 1);
      chk("bp running", running, 0);
      chk("bp count", cycle_count, ecnt(2));
      adv(11); chk("bp no cpu_ce", cpu_ce, 0);
      run = 1'b0;
      adv(13); run = 1'b1;
      adv(15); chk("bp held cpu_ce", cpu_ce, 0);
      adv(17);
      chk("bp resume running", running, 1);
      chk("bp resume halted", halted, 0);
      adv(19); chk("bp exec5 cpu_ce", cpu_ce, 1); i_addr = 8'h06;
      adv(21); chk("bp past running", running, 1);
      adv(23); chk("bp exec6 cpu_ce", cpu_ce, 1);
      adv(24); chk("bp count2", cycle_count, ecnt(4));
      // counter wrap: 17 pulses at 3,7,..,67
      do_reset();
      bp_valid = 1'b0; run = 1'b1;
      adv(60); chk("wrap count15", cycle_count, ecnt(15));
      adv(65); chk("wrap count16", cycle_count, ecnt(16));
      adv(67); chk("wrap cpu_ce", cpu_ce, 1);
      adv(68); chk("wrap count17", cycle_count, ecnt(17));
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
